// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ sources,
// with a one-entry registered write stage. Define WRITE_FORWARD_EN to add stage forwarding.
module regfile_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_data,
    output logic                     rf_we,
    output logic [1:0]               grant_id
`ifdef WRITE_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0]        fwd_addr1,
    input  logic [ADDR_W-1:0]        fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2
`endif
);

    logic [1:0]        ptr;
    logic [1:0]        ptr_next;
    logic              stage_v;
    logic              grant_found;
    logic [1:0]        grant_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    int                idx;

    // Search from ptr upward, wrapping; the first valid requester wins unless stalled.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        req_ready   = '0;
        win_addr    = '0;
        win_data    = '0;
        idx         = 0;
        if (!hold) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (!grant_found && req_valid[idx]) begin
                    grant_found    = 1'b1;
                    grant_idx      = 2'(idx);
                    req_ready[idx] = 1'b1;
                    win_addr       = req_addr[idx*ADDR_W +: ADDR_W];
                    win_data       = req_data[idx*DATA_W +: DATA_W];
                end
            end
        end
        ptr_next = 2'((int'(grant_idx) + 1) % NREQ);
    end

    // The stage never stalls; without a grant it empties but keeps its last address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 2'd0;
            stage_v  <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
            grant_id <= 2'd0;
        end else begin
            stage_v <= grant_found;
            if (grant_found) begin
                ptr      <= ptr_next;
                rf_addr  <= win_addr;
                rf_data  <= win_data;
                grant_id <= grant_idx;
            end
        end
    end

    assign rf_we = stage_v;

`ifdef WRITE_FORWARD_EN
    // Lets readers see a write that the register file commits only at the next edge.
    assign fwd_hit1  = stage_v && (fwd_addr1 == rf_addr);
    assign fwd_hit2  = stage_v && (fwd_addr2 == rf_addr);
    assign fwd_data1 = fwd_hit1 ? rf_data : '0;
    assign fwd_data2 = fwd_hit2 ? rf_data : '0;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port (address, data, write enable) between NREQ independent write sources, such as the ALU result path, the load path and the immediate-load path. It uses round-robin arbitration and a per-requester valid/ready handshake. The winning write is registered into a one-entry stage that directly drives the register file write port, so the write port always sees clean, glitch-free signals. Sits between the execution/load units and the register file.

## Interface
Parameters:
- NREQ, 3, number of write requesters (2..4)
- ADDR_W, 5, register address width
- DATA_W, 8, register data width

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  write request per requester
- req_addr  input  NREQ*ADDR_W  destination register; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  input  NREQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  NREQ  grant/accept, one-hot or zero, combinational
- hold  input  1  suppress new grants (pipeline stall)
- rf_addr  output  ADDR_W  to register file write address
- rf_data  output  DATA_W  to register file write data
- rf_we  output  1  to register file write enable
- grant_id  output  2  index of the requester whose write is in the stage
- fwd_addr1, fwd_addr2  input  ADDR_W each  read addresses to check (WRITE_FORWARD_EN only)
- fwd_hit1, fwd_hit2  output  1 each  stage holds a write to that address (WRITE_FORWARD_EN only)
- fwd_data1, fwd_data2  output  DATA_W each  staged data on hit, else 0 (WRITE_FORWARD_EN only)

## Operation
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge of clk.
  - A requester holds valid, addr and data stable until ready.
  - Valid never depends on ready.
- Arbitration: combinational round-robin.
  - Search starts at pointer ptr and proceeds ptr, ptr+1, … mod NREQ.
  - The first valid requester gets req_ready.
  - When hold=1 or no requester is valid, req_ready is all zero.
- Pointer update: after a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr is unchanged.
- Fairness: a continuously valid requester is granted within NREQ cycles when hold=0.
- Stage update on each edge:
  - If there is a grant: stage_v <= 1, and rf_addr, rf_data, grant_id are loaded from the winner.
  - Otherwise: stage_v <= 0, and rf_addr, rf_data, grant_id hold their values.
  - rf_we = stage_v.
- The stage never back-pressures: a new grant may occur every cycle, regardless of stage occupancy. Throughput is one write per cycle.
- Only one write reaches the port per cycle, so same-address collisions cannot occur. Program order across requesters is the grant order.
- Reset values: stage_v=0, rf_we=0, rf_addr=0, rf_data=0, grant_id=0, ptr=0. req_ready is combinational and is therefore 0 whenever no request is valid.
- Reset asserted mid-operation: the staged write is dropped, rf_we falls asynchronously, and nothing is committed.

## Timing
- Accept at edge N → rf_we=1 with the winner's addr/data during cycle N..N+1 → the register file commits at edge N+1. Latency from accept to commit is 1 cycle.
- req_ready is combinational from req_valid, hold and ptr. There is no path from rf_* back to req_ready.
- hold asserted in cycle N: no accept at edge N. The stage drains, so rf_we=0 after edge N.
- Back-to-back grants produce rf_we continuously high, with address and data changing each cycle.

## Configuration
- WRITE_FORWARD_EN defined:
  - Adds the fwd_* ports and forwarding logic.
  - fwd_hitK = stage_v && (fwd_addrK == rf_addr), combinational.
  - fwd_dataK = rf_data on hit, else 0.
  - Readers use this to see a write the register file has not yet committed.
- WRITE_FORWARD_EN undefined: the fwd_* ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert rst_n=0 while the stage holds addr 5 / data 0xA5 → rf_we=0, rf_addr=0, rf_data=0, grant_id=0 immediately. After release, the first grant goes to requester 0.
- Single request: req_valid=3'b010, addr 5, data 0xA5 → req_ready=3'b010 in the same cycle. The next cycle shows rf_we=1, rf_addr=5, rf_data=0xA5, grant_id=1. The following cycle shows rf_we=0.
- Round-robin: all three requesters held valid for 6 cycles → grants 0,1,2,0,1,2, with rf_we high for 6 consecutive cycles.
- Pointer rotation: grant requester 2 alone, then requesters 0 and 2 valid together → requester 0 wins, then 2.
- Hold: all requesters valid with hold=1 for 3 cycles → req_ready=0 and rf_we=0 from the second cycle. Release hold → grant resumes at the saved ptr.
- Forwarding (WRITE_FORWARD_EN): stage holds addr 7 / data 0x3C; fwd_addr1=7, fwd_addr2=8 → fwd_hit1=1, fwd_data1=0x3C, fwd_hit2=0, fwd_data2=0x00.
